fetch_queue: RTL

//  Decoupling FIFO between the fetch stage (program counter + instruction memory) and decode.

---
 rtl/riscvx_pkg.sv | 13 +
 rtl/fetch_queue_if.sv | 29 ++
 rtl/fq_storage.sv | 28 ++
 rtl/fetch_queue.sv | 103 ++++++++++
 4 files changed

// File: rtl/riscvx_pkg.sv
// Shared fetch-side types and constants: datapath width, the canonical NOP
// and the {pc, instr} entry carried through the fetch queue.
package riscvx_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: push side from fetch, head side to decode,
// plus the redirect flush and occupancy.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    import riscvx_pkg::*;

    logic                     flush;
    logic                     in_valid;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_instr;
    logic                     in_ready;
    logic                     out_valid;
    logic [XLEN-1:0]          out_pc;
    logic [XLEN-1:0]          out_instr;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: one synchronous write port and one
// asynchronous read port feeding the head outputs.
module fq_storage
    import riscvx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  fetch_entry_t             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output fetch_entry_t             rd_data
);

    fetch_entry_t mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by the pointers, so
    // stale contents are never observable and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode with flush on taken redirect.
// Define FETCH_QUEUE_BYPASS_EN to forward input to head when the queue is empty.
module fetch_queue
    import riscvx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  count_q, count_d;
    logic         empty, full;
    logic         push, pop;
    logic         store_push, store_pop;
    fetch_entry_t head, wr_entry;

    // Equal pointers mean empty; differing only in the wrap bit means full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign wr_entry = '{pc: fq.in_pc, instr: fq.in_instr};

    assign push = fq.in_valid && fq.in_ready && !fq.flush;
    assign pop  = fq.out_valid && fq.out_ready && !fq.flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass = empty && fq.in_valid && !fq.flush;
    // A bypassed entry taken by decode the same cycle never touches storage.
    assign store_push = push && !(bypass && fq.out_ready);
    assign store_pop  = pop && !empty;
`else
    assign store_push = push;
    assign store_pop  = pop;
`endif

    assign fq.in_ready = !full;
    assign fq.count    = count_q;

    // NOTE: every output gets a default first so no path through the block
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        fq.out_valid = !empty;
        fq.out_pc    = '0;
        fq.out_instr = NOP_INSTR;
        if (!empty) begin
            fq.out_pc    = head.pc;
            fq.out_instr = head.instr;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (bypass) begin
            fq.out_valid = 1'b1;
            fq.out_pc    = fq.in_pc;
            fq.out_instr = fq.in_instr;
        end
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (store_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, store_push} - {{AW{1'b0}}, store_pop};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .wr_en   (store_push),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (head)
    );

endmodule
